// File: rtl/mem_access_unit.sv
// Data-memory access stage: takes the ALU address and rd2 store data, runs a
// ready/ack handshake on the data bus, aligns store lanes and extracts/extends
// load data. busy holds the core until the done pulse.
// Optional build macro: MEM_TIMEOUT_EN adds a bus-ack timeout that ends the
// access with err after TIMEOUT REQ cycles.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // The counter must be able to reach TIMEOUT-1.
    if (TIMEOUT == 0 || CNT_W < $clog2(TIMEOUT + 1)) begin : g_bad_cfg
        $error("mem_access_unit: CNT_W too small for TIMEOUT");
    end

    logic [1:0]  state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        bad_req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Byte-lane enables, replicated store data and alignment check for the request.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        unique case (size_i)
            2'b00: begin
                lane_be    = 4'b0001 << addr_i[1:0];
                lane_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << addr_i[1:0];
                lane_wdata = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_i;
            end
            default: begin
                lane_be    = 4'b0000;
                lane_wdata = 32'h0;
            end
        endcase
        bad_req = (size_i == 2'b11) ||
                  (size_i == 2'b01 && addr_i[0]) ||
                  (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    end

    // Load extract and extend; only aligned offsets reach here for halfwords.
    always_comb begin
        unique case (off_q)
            2'd0:    ld_byte = bus_rdata_i[7:0];
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            default: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        unique case (size_q)
            2'b00:   ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    // Next-state logic for the access FSM and its captured fields.
    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (bad_req) begin
                        // Rejected without touching the bus.
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = StReq;
                        bus_we_d    = we_i;
                        bus_addr_d  = {addr_i[31:2], 2'b00};
                        bus_be_d    = lane_be;
                        bus_wdata_d = lane_wdata;
                        size_d      = size_i;
                        uns_d       = uns_i;
                        off_d       = addr_i[1:0];
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            StReq: begin
                if (bus_ack_i) begin
                    state_d     = StDone;
                    rdata_d     = bus_we_q ? 32'h0 : ld_data;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_be_d    = 4'b0000;
                    bus_wdata_d = 32'h0;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = StDone;
                    err_d       = 1'b1;
                    rdata_d     = 32'h0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_be_d    = 4'b0000;
                    bus_wdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
        bus_req_o   = (state_q == StReq);
        err_o       = err_q;
        rdata_o     = rdata_q;
        bus_we_o    = bus_we_q;
        bus_addr_o  = bus_addr_q;
        bus_be_o    = bus_be_q;
        bus_wdata_o = bus_wdata_q;
    end

endmodule
